ov7670_stream_gen: RTL and testbench

OV7670_STREAM_GEN -- requirements
Module: ov7670_stream_gen

---
 rtl/ov7670_stream_gen_pkg.sv | 54 +++++
 rtl/pattern_gen_565.sv | 36 +++
 rtl/ov7670_stream_gen.sv | 139 +++++++++++++
 tb/tb_ov7670_stream_gen.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ov7670_stream_gen_pkg.sv
// Shared types and constants for the OV7670-style camera stream generator.
// Holds the frame state encoding, pattern selects, colour-bar palette and default timing.
package ov7670_stream_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBP    = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFP    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_SOLID = 2'd1,
    PAT_GRAD  = 2'd2,
    PAT_ADDR  = 2'd3
  } pattern_t;

  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  localparam int DEF_SCREEN_X  = 320;
  localparam int DEF_SCREEN_Y  = 240;
  localparam int DEF_H_BLANK   = 144;
  localparam int DEF_VS_LINES  = 3;
  localparam int DEF_VBP_LINES = 17;
  localparam int DEF_VFP_LINES = 10;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = BAR_WHITE;
      3'd1:    bar_color = BAR_YELLOW;
      3'd2:    bar_color = BAR_CYAN;
      3'd3:    bar_color = BAR_GREEN;
      3'd4:    bar_color = BAR_MAGENTA;
      3'd5:    bar_color = BAR_RED;
      3'd6:    bar_color = BAR_BLUE;
      default: bar_color = BAR_BLACK;
    endcase
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pattern_gen_565.sv
// Combinational RGB565 test-pattern source: maps (pattern, solid, x, y) to one pixel.
module pattern_gen_565
  import ov7670_stream_gen_pkg::*;
#(
  parameter int SCREEN_X = DEF_SCREEN_X
) (
  input  logic [1:0]  i_pattern,
  input  logic [15:0] i_solid,
  input  logic [15:0] i_x,
  input  logic [15:0] i_y,
  output logic [15:0] o_pixel
);

  localparam int BAR_W    = SCREEN_X / 8;
  localparam bit HAS_BARS = (BAR_W > 0);
  localparam int BAR_DIV  = HAS_BARS ? BAR_W : 1;

  logic [15:0] w_bar_idx;
  logic [16:0] w_addr;

  always_comb begin
    w_bar_idx = i_x / 16'(BAR_DIV);
    w_addr    = 17'(i_x) + 17'(i_y) * 17'(SCREEN_X);
    o_pixel   = 16'h0000;
    case (i_pattern)
      PAT_BARS: begin
        // Columns past the eighth full bar fall back to black.
        if (HAS_BARS && (w_bar_idx < 16'd8)) o_pixel = bar_color(w_bar_idx[2:0]);
      end
      PAT_SOLID: o_pixel = i_solid;
      PAT_GRAD:  o_pixel = {i_x[4:0], i_y[5:0], i_x[4:0]};
      default:   o_pixel = w_addr[15:0];
    endcase
  end

endmodule

// File: rtl/ov7670_stream_gen.sv
// OV7670-style camera output generator: vsync/href/8-bit RGB565 byte stream with test patterns.
// Every output is registered from the next-cycle position so it lines up with the counters.
module ov7670_stream_gen
  import ov7670_stream_gen_pkg::*;
#(
  parameter int SCREEN_X  = DEF_SCREEN_X,
  parameter int SCREEN_Y  = DEF_SCREEN_Y,
  parameter int H_BLANK   = DEF_H_BLANK,
  parameter int VS_LINES  = DEF_VS_LINES,
  parameter int VBP_LINES = DEF_VBP_LINES,
  parameter int VFP_LINES = DEF_VFP_LINES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  pattern,
  input  logic [15:0] solid_rgb565,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  px_data,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output state_t      dbg_state
);

  localparam int L     = 2 * SCREEN_X + H_BLANK;
  localparam int HW    = cnt_width(L);
  localparam int MAX_A = (VS_LINES > VBP_LINES) ? VS_LINES : VBP_LINES;
  localparam int MAX_B = (SCREEN_Y > VFP_LINES) ? SCREEN_Y : VFP_LINES;
  localparam int MAX_L = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int LW    = cnt_width(MAX_L);

  localparam logic [HW-1:0] H_LAST = HW'(L - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(2 * SCREEN_X);

  state_t        r_state;
  logic [HW-1:0] r_h;
  logic [LW-1:0] r_l;
  logic [1:0]    r_pat;
  logic [15:0]   r_solid;
  logic          r_vsync;
  logic          r_href;
  logic [7:0]    r_px;
  logic          r_done;
  logic [15:0]   r_cnt;

  state_t        w_nstate;
  logic [HW-1:0] w_nh;
  logic [LW-1:0] w_nl;
  logic          w_line_last;
  logic          w_start;
  logic          w_href_next;
  logic          w_done_next;
  logic [15:0]   w_pixel;

  always_comb begin
    w_nstate    = r_state;
    w_nh        = '0;
    w_nl        = r_l;
    w_line_last = 1'b0;
    case (r_state)
      ST_VSYNC:  w_line_last = (r_l == LW'(VS_LINES - 1));
      ST_VBP:    w_line_last = (r_l == LW'(VBP_LINES - 1));
      ST_ACTIVE: w_line_last = (r_l == LW'(SCREEN_Y - 1));
      ST_VFP:    w_line_last = (r_l == LW'(VFP_LINES - 1));
      default:   w_line_last = 1'b0;
    endcase

    if (r_state == ST_IDLE) begin
      w_nl = '0;
      if (en) w_nstate = ST_VSYNC;
    end else if (r_h == H_LAST) begin
      if (w_line_last) begin
        w_nl = '0;
        case (r_state)
          ST_VSYNC:  w_nstate = ST_VBP;
          ST_VBP:    w_nstate = ST_ACTIVE;
          ST_ACTIVE: w_nstate = ST_VFP;
          default:   w_nstate = en ? ST_VSYNC : ST_IDLE;
        endcase
      end else begin
        w_nl = r_l + 1'b1;
      end
    end else begin
      w_nh = r_h + 1'b1;
    end

    // Pattern/colour are captured only when a new frame begins.
    w_start     = (w_nstate == ST_VSYNC) && ((r_state == ST_IDLE) || (r_state == ST_VFP));
    w_href_next = (w_nstate == ST_ACTIVE) && (w_nh < H_ACT);
    w_done_next = (w_nstate == ST_VFP) && (w_nh == H_LAST) && (w_nl == LW'(VFP_LINES - 1));
  end

  pattern_gen_565 #(
    .SCREEN_X (SCREEN_X)
  ) u_pattern (
    .i_pattern (r_pat),
    .i_solid   (r_solid),
    .i_x       (16'(w_nh >> 1)),
    .i_y       (16'(w_nl)),
    .o_pixel   (w_pixel)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_h     <= '0;
      r_l     <= '0;
      r_pat   <= '0;
      r_solid <= '0;
      r_vsync <= 1'b0;
      r_href  <= 1'b0;
      r_px    <= '0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nstate;
      r_h     <= w_nh;
      r_l     <= w_nl;
      if (w_start) begin
        r_pat   <= pattern;
        r_solid <= solid_rgb565;
      end
      r_vsync <= (w_nstate == ST_VSYNC);
      r_href  <= w_href_next;
      r_px    <= w_href_next ? (w_nh[0] ? w_pixel[7:0] : w_pixel[15:8]) : 8'h00;
      r_done  <= w_done_next;
      if (w_done_next) r_cnt <= r_cnt + 16'd1;
    end
  end

  assign vsync      = r_vsync;
  assign href       = r_href;
  assign px_data    = r_px;
  assign frame_done = r_done;
  assign frame_cnt  = r_cnt;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Self-checking bench for ov7670_stream_gen on a small 8x4 frame (L=20, 140 cycles per frame).
module tb_ov7670_stream_gen;
  import ov7670_stream_gen_pkg::*;

  localparam int SX    = 8;
  localparam int SY    = 4;
  localparam int HB    = 4;
  localparam int VS    = 1;
  localparam int VBP   = 1;
  localparam int VFP   = 1;
  localparam int L     = 2 * SX + HB;
  localparam int FRAME = (VS + VBP + SY + VFP) * L;

  localparam logic [15:0] REF_BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                           16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  pattern;
  logic [15:0] solid_rgb565;
  logic        vsync;
  logic        href;
  logic [7:0]  px_data;
  logic        frame_done;
  logic [15:0] frame_cnt;
  state_t      dbg_state;

  always #5 clk = ~clk;

  ov7670_stream_gen #(
    .SCREEN_X  (SX),
    .SCREEN_Y  (SY),
    .H_BLANK   (HB),
    .VS_LINES  (VS),
    .VBP_LINES (VBP),
    .VFP_LINES (VFP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .pattern      (pattern),
    .solid_rgb565 (solid_rgb565),
    .vsync        (vsync),
    .href         (href),
    .px_data      (px_data),
    .frame_done   (frame_done),
    .frame_cnt    (frame_cnt),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         exp_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference pixel straight from the pattern definitions.
  function automatic logic [15:0] ref_pixel(input int pat, input logic [15:0] solid,
                                            input int x, input int y);
    int bw;
    bw = SX / 8;
    case (pat)
      0:       return (bw > 0 && x / bw < 8) ? REF_BARS[x / bw] : 16'h0000;
      1:       return solid;
      2:       return 16'((((x % 32) << 11) | ((y % 64) << 5) | (x % 32)));
      default: return 16'((x + y * SX) % 65536);
    endcase
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_vsync"}, vsync, 0);
    check({tag, "_href"}, href, 0);
    check({tag, "_px"}, px_data, 0);
    check({tag, "_done"}, frame_done, 0);
    check({tag, "_cnt"}, frame_cnt, exp_cnt);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- driver ----------------
  // Called #1 after an edge ("cycle 0"); runs one frame checking each cycle t=1..FRAME.
  // chg: cycle at which pattern/solid are scrambled; en_off: cycle en drops; rst_at: cycle reset hits.
  task automatic run_frame(input logic [1:0] pat_f, input logic [15:0] solid_f,
                           input int en_off, input int chg, input int rst_at);
    int line, h, act, first_href, href_len;
    logic e_vs, e_hr;
    logic [15:0] pix;
    pattern      = pat_f;
    solid_rgb565 = solid_f;
    en           = 1'b1;
    first_href   = -1;
    href_len     = 0;
    for (int t = 1; t <= FRAME; t++) begin
      @(posedge clk);
      #1;
      line = (t - 1) / L;
      h    = (t - 1) % L;
      act  = line - (VS + VBP);
      e_vs = (line < VS);
      e_hr = (act >= 0) && (act < SY) && (h < 2 * SX);
      if (e_hr) begin
        pix = ref_pixel(int'(pat_f), solid_f, h / 2, act);
        exp_q.push_back((h % 2 == 0) ? pix[15:8] : pix[7:0]);
      end
      check("vsync", vsync, e_vs);
      check("href", href, e_hr);
      check("frame_done", frame_done, (t == FRAME));
      if (href) begin
        if (first_href < 0) first_href = t;
        href_len++;
        check("px_avail", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("px_data", px_data, exp_q.pop_front());
      end else begin
        check("px_blank", px_data, 0);
      end
      if (t == 1) check("cnt_start", frame_cnt, exp_cnt);
      if (t == FRAME) begin
        exp_cnt = (exp_cnt + 1) % 65536;
        check("cnt_end", frame_cnt, exp_cnt);
      end
      if (t == chg) begin
        pattern      = 2'($urandom_range(0, 3));
        solid_rgb565 = 16'($urandom);
      end
      if (t == en_off) en = 1'b0;
      if (t == rst_at) begin
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_cnt = 0;
        exp_q.delete();
        check_idle("midreset");
        rst = 1'b1;
        return;
      end
    end
    check("first_href", first_href, (VS + VBP) * L + 1);
    check("href_len", href_len, SY * 2 * SX);
    check("q_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    rst          = 1'b0;
    en           = 1'($urandom_range(0, 1));
    pattern      = 2'($urandom_range(0, 3));
    solid_rgb565 = 16'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b1;
    en  = 1'b0;

    // Bars frame with mid-frame pattern scrambling, then back-to-back frames.
    run_frame(2'd0, 16'($urandom), 0, 60, 0);
    run_frame(2'd3, 16'($urandom), 0, 30, 0);
    for (int k = 0; k < 4; k++)
      run_frame(2'($urandom_range(0, 3)), 16'($urandom), 0, $urandom_range(1, FRAME - 1), 0);
    run_frame(2'd1, 16'($urandom), 0, 90, 0);
    run_frame(2'd2, 16'($urandom), 0, 45, 0);

    // en dropped mid-frame: frame completes, then stays idle.
    run_frame(2'($urandom_range(0, 3)), 16'($urandom), 60, 0, 0);
    repeat (5) begin
      @(posedge clk);
      #1;
      check_idle("after_en_off");
    end

    // Reset during the active region, then restart from VSYNC.
    run_frame(2'd2, 16'($urandom), 0, 0, 70);
    run_frame(2'($urandom_range(0, 3)), 16'($urandom), 0, 0, 0);
    run_frame(2'd0, 16'($urandom), 120, 10, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check_idle("final_idle");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
